// File: rtl/multiword_add_sequencer_pkg.sv
// Shared types and default sizing for the multi-word add sequencer.
package multiword_add_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int W_DEF = 64;
    localparam int L_DEF = 16;
    localparam int M_DEF = 8;

endpackage

// File: rtl/fastAdder.sv
// L-bit chunk adder: a fast lower (L-M)-bit section feeding an M-bit
// ripple-carry upper section. Kept as its own hierarchy so its placement
// constraints survive synthesis.
(* KEEP_HIERARCHY = "TRUE" *)
module fastAdder #(
    parameter int L = 16,
    parameter int M = 8
) (
    input  logic [L-1:0] a,
    input  logic [L-1:0] b,
    input  logic         cin,
    output logic [L-1:0] sum,
    output logic         cout
);

    localparam int LO = L - M;

    logic [LO:0] lo_sum;
    logic [M:0]  c;

    assign lo_sum = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + {{LO{1'b0}}, cin};
    assign sum[LO-1:0] = lo_sum[LO-1:0];
    assign c[0] = lo_sum[LO];

    // Upper section: explicit full-adder chain so each cell can be placed.
    for (genvar i = 0; i < M; i++) begin : g_rca
        assign sum[LO+i] = a[LO+i] ^ b[LO+i] ^ c[i];
        assign c[i+1]    = (a[LO+i] & b[LO+i]) | (c[i] & (a[LO+i] ^ b[LO+i]));
    end

    assign cout = c[M];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Feeds a W-bit operand pair through one L-bit fastAdder as NCHUNK
// successive chunks (LSB first), registering the carry between chunks,
// and returns the assembled sum over a valid/ready handshake.
module multiword_add_sequencer
    import multiword_add_sequencer_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int L = L_DEF,
    parameter int M = M_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout
);

    localparam int NCHUNK = W / L;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if ((W % L) != 0 || M >= L || M < 1) begin : g_param_check
        $error("multiword_add_sequencer: W must be a multiple of L and 0 < M < L");
    end

    state_t          state;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [W-1:0]    sum_sh;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic [L-1:0]    chunk_sum;
    logic            chunk_cout;
    logic [W+L-1:0]  sum_cat;

    // Adder inputs come straight from the operand-register LSB chunks.
    (* KEEP_HIERARCHY = "TRUE" *)
    fastAdder #(
        .L (L),
        .M (M)
    ) u_fast_adder (
        .a    (a_sh[L-1:0]),
        .b    (b_sh[L-1:0]),
        .cin  (carry),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    // New chunk enters the result register from the top; works for W == L too.
    assign sum_cat  = {chunk_sum, sum_sh};
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_sum  = sum_sh;

    // Sequencer FSM: accept, step one chunk per cycle, hold result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= in_a;
                        b_sh  <= in_b;
                        carry <= in_cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> L;
                    b_sh   <= b_sh >> L;
                    sum_sh <= sum_cat[W+L-1:L];
                    carry  <= chunk_cout;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(NCHUNK - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_cout  <= chunk_cout;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            // Back-to-back: take the next pair in the drain cycle.
                            a_sh  <= in_a;
                            b_sh  <= in_b;
                            carry <= in_cin;
                            cnt   <= '0;
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
